// File: rtl/spi_pkg.sv
// Shared types and helpers for the single-CS SPI responder.
package spi_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_t;

    function automatic logic spi_cpol(input int mode);
        return mode[1];
    endfunction

    function automatic logic spi_cpha(input int mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_slave_with_single_cs_if.sv
// SPI pin group between an external master and the responder.
interface spi_slave_with_single_cs_if;

    logic SPI_Clk;
    logic SPI_MOSI;
    logic SPI_CS_n;
    logic SPI_MISO;
    logic SPI_MISO_En;

    modport master (
        output SPI_Clk, SPI_MOSI, SPI_CS_n,
        input  SPI_MISO, SPI_MISO_En
    );

    modport slave (
        input  SPI_Clk, SPI_MOSI, SPI_CS_n,
        output SPI_MISO, SPI_MISO_En
    );

endinterface

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser with a history flop; edges are taken between the
// last sync stage and the history stage.
module spi_input_sync
    import spi_pkg::*;
#(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic [W-1:0] i_D,
    output logic [W-1:0] o_Q,
    output logic [W-1:0] o_Rise,
    output logic [W-1:0] o_Fall
);

    logic [W-1:0] sync_p [SYNC_STAGES];
    logic [W-1:0] hist_p;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= RST_VAL;
            hist_p <= RST_VAL;
        end else begin
            // pin -> sync chain -> history
            sync_p[0] <= i_D;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            hist_p <= sync_p[SYNC_STAGES-1];
        end
    end

    assign o_Q    = sync_p[SYNC_STAGES-1];
    assign o_Rise = o_Q & ~hist_p;
    assign o_Fall = ~o_Q & hist_p;

endmodule

// File: rtl/spi_slave_with_single_cs.sv
// SPI responder: oversampled SCK/MOSI/CS_n, MSB-first byte RX, staged TX bytes
// on MISO, framed by a single chip select.
module spi_slave_with_single_cs
    import spi_pkg::*;
#(
    parameter int         SPI_MODE         = 0,
    parameter int         MAX_BYTES_PER_CS = 2,
    parameter logic [7:0] TX_DEFAULT       = 8'hFF,
    localparam int        CNT_W            = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [7:0]       i_TX_Byte,
    input  logic             i_TX_DV,
    output logic             o_TX_Ready,
    output logic             o_TX_Underrun,
    output logic             o_RX_DV,
    output logic [7:0]       o_RX_Byte,
    output logic [CNT_W-1:0] o_RX_Count,
    output logic             o_CS_Active,
    output logic             o_Frame_Done,
    output logic             o_Frame_Abort,
    spi_slave_with_single_cs_if.slave spi
);

    localparam logic             CPOL           = spi_cpol(SPI_MODE);
    localparam logic             CPHA           = spi_cpha(SPI_MODE);
    localparam logic             SAMPLE_ON_RISE = (CPOL == CPHA);
    localparam logic [CNT_W-1:0] CNT_MAX        = CNT_W'(MAX_BYTES_PER_CS);

    logic [2:0] sync_q, sync_rise, sync_fall;
    logic [2:0] unused_sync;

    // Bit order: {SCK, MOSI, CS_n}
    spi_input_sync #(
        .W       (3),
        .RST_VAL ({CPOL, 1'b0, 1'b1})
    ) u_sync (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_D    ({spi.SPI_Clk, spi.SPI_MOSI, spi.SPI_CS_n}),
        .o_Q    (sync_q),
        .o_Rise (sync_rise),
        .o_Fall (sync_fall)
    );

    assign unused_sync = {sync_q[2], sync_rise[1], sync_fall[1]};

    logic sck_sample, sck_shift, cs_fall, cs_rise, mosi;

    assign sck_sample = SAMPLE_ON_RISE ? sync_rise[2] : sync_fall[2];
    assign sck_shift  = SAMPLE_ON_RISE ? sync_fall[2] : sync_rise[2];
    assign cs_fall    = sync_fall[0];
    assign cs_rise    = sync_rise[0];
    assign mosi       = sync_q[1];

    spi_state_t state;
    logic [6:0] rx_shift;
    logic [2:0] rx_bit_cnt;
    logic [7:0] tx_shift;
    logic [2:0] tx_cnt;
    logic       from_hold;
    logic       consume_pending;
    logic [7:0] hold_byte;
    logic       hold_full;
    logic [1:0] settle;
    logic       armed;
    logic [7:0] next_byte;

    assign next_byte = hold_full ? hold_byte : TX_DEFAULT;

    // A frame may only open once CS_n has been seen high through a settled
    // sync chain, so a reset taken mid-frame cannot re-enter that frame.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state           <= IDLE;
            rx_shift        <= '0;
            rx_bit_cnt      <= '0;
            tx_shift        <= '0;
            tx_cnt          <= '0;
            from_hold       <= 1'b0;
            consume_pending <= 1'b0;
            hold_byte       <= '0;
            hold_full       <= 1'b0;
            settle          <= '0;
            armed           <= 1'b0;
            o_RX_DV         <= 1'b0;
            o_RX_Byte       <= '0;
            o_RX_Count      <= '0;
            o_TX_Underrun   <= 1'b0;
            o_Frame_Done    <= 1'b0;
            o_Frame_Abort   <= 1'b0;
        end else begin
            o_RX_DV       <= 1'b0;
            o_TX_Underrun <= 1'b0;
            o_Frame_Done  <= 1'b0;
            o_Frame_Abort <= 1'b0;
            settle        <= {settle[0], 1'b1};
            if (settle[1] && sync_q[0]) armed <= 1'b1;

            if (i_TX_DV && !hold_full) begin
                hold_byte <= i_TX_Byte;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (armed && cs_fall) begin
                        state      <= ACTIVE;
                        rx_bit_cnt <= '0;
                        o_RX_Count <= '0;
                        if (!CPHA) begin
                            tx_shift        <= next_byte;
                            from_hold       <= hold_full;
                            consume_pending <= 1'b1;
                            tx_cnt          <= '0;
                        end else begin
                            consume_pending <= 1'b0;
                            tx_cnt          <= 3'd7;
                        end
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state           <= IDLE;
                        o_Frame_Done    <= 1'b1;
                        o_Frame_Abort   <= (rx_bit_cnt != 3'd0);
                        rx_bit_cnt      <= '0;
                        consume_pending <= 1'b0;
                    end else if (sck_sample) begin
                        if (consume_pending) begin
                            consume_pending <= 1'b0;
                            if (from_hold) hold_full     <= 1'b0;
                            else           o_TX_Underrun <= 1'b1;
                        end
                        if (rx_bit_cnt == 3'd7) begin
                            o_RX_Byte  <= {rx_shift, mosi};
                            o_RX_DV    <= 1'b1;
                            rx_bit_cnt <= '0;
                            if (o_RX_Count != CNT_MAX) o_RX_Count <= o_RX_Count + CNT_W'(1);
                        end else begin
                            rx_shift   <= {rx_shift[5:0], mosi};
                            rx_bit_cnt <= rx_bit_cnt + 3'd1;
                        end
                    end else if (sck_shift) begin
                        if (tx_cnt == 3'd7) begin
                            tx_shift        <= next_byte;
                            from_hold       <= hold_full;
                            consume_pending <= 1'b1;
                            tx_cnt          <= '0;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            tx_cnt   <= tx_cnt + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_TX_Ready      = ~hold_full;
    assign o_CS_Active     = (state == ACTIVE);
    assign spi.SPI_MISO    = (state == ACTIVE) & tx_shift[7];
    assign spi.SPI_MISO_En = (state == ACTIVE);

endmodule
